// File: rtl/dds_ctrl_pkg.sv
// Shared types and helpers for the DDS frequency-sweep controller.
// Width-generic arithmetic is done at PINC_MAX_W; callers zero-extend and truncate.
package dds_ctrl_pkg;

    localparam int unsigned PINC_W_DEFAULT  = 16;
    localparam int unsigned DWELL_W_DEFAULT = 16;
    localparam int unsigned PINC_MAX_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_STEP,
        ST_FINISH
    } sweep_state_t;

    // Saturating step toward stop. Any carry past the caller's width also
    // exceeds stop, so the compare against stop covers the carry case.
    function automatic logic [PINC_MAX_W-1:0] next_pinc(
        input logic [PINC_MAX_W-1:0] cur,
        input logic [PINC_MAX_W-1:0] stop,
        input logic [PINC_MAX_W-1:0] step,
        input logic                  up
    );
        logic [PINC_MAX_W:0]   sum;
        logic [PINC_MAX_W-1:0] res;
        sum = {1'b0, cur} + {1'b0, step};
        res = stop;
        if (up) begin
            if (sum < {1'b0, stop})
                res = sum[PINC_MAX_W-1:0];
        end else if ((cur >= step) && ((cur - step) > stop)) begin
            res = cur - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; load value is max(dwell,1) and expiry flags the
// last cycle of the dwell window.
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expire
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign o_expire = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear DDS phase-increment sweep sequencer with registered config-bus outputs.
// Define DDS_SWEEP_CONT_EN to enable continuous-repeat sweeps via i_cont.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned PINC_W  = PINC_W_DEFAULT,
    parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_cont,
    input  logic [PINC_W-1:0]  i_start_pinc,
    input  logic [PINC_W-1:0]  i_stop_pinc,
    input  logic [PINC_W-1:0]  i_step_pinc,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [PINC_W-1:0]  i_poff,
    output logic [PINC_W-1:0]  o_pinc,
    output logic [PINC_W-1:0]  o_poff,
    output logic               o_cfg_valid,
    output logic               o_busy,
    output logic               o_done
);

    sweep_state_t       state_q, state_d;
    logic [PINC_W-1:0]  stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               up_q;
    logic               accept;
    logic               last_point;
    logic               timer_load;
    logic               timer_expire;
    logic [DWELL_W-1:0] timer_dwell;
    logic [PINC_W-1:0]  step_val;
    logic [PINC_W-1:0]  pinc_d;

`ifdef DDS_SWEEP_CONT_EN
    logic [PINC_W-1:0]  start_q;
    logic               cont_q;
`else
    logic               cont_unused;
    assign cont_unused = i_cont;
`endif

    assign accept      = (state_q == ST_IDLE) && i_start && !i_abort;
    assign last_point  = (o_pinc == stop_q) || (step_q == '0);
    assign step_val    = PINC_W'(next_pinc(PINC_MAX_W'(o_pinc), PINC_MAX_W'(stop_q),
                                           PINC_MAX_W'(step_q), up_q));
    assign timer_load  = (state_d == ST_LOAD) || (state_d == ST_STEP);
    assign timer_dwell = accept ? i_dwell : dwell_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start)
                    state_d = ST_LOAD;
            end
            // The strobe cycle itself is the first dwell cycle.
            ST_LOAD, ST_DWELL, ST_STEP: begin
                if (!timer_expire)
                    state_d = ST_DWELL;
                else if (!last_point)
                    state_d = ST_STEP;
                else begin
`ifdef DDS_SWEEP_CONT_EN
                    state_d = cont_q ? ST_LOAD : ST_FINISH;
`else
                    state_d = ST_FINISH;
`endif
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (i_abort)
            state_d = ST_IDLE;
    end

    always_comb begin
        pinc_d = o_pinc;
        if (state_d == ST_STEP) begin
            pinc_d = step_val;
        end else if (state_d == ST_LOAD) begin
`ifdef DDS_SWEEP_CONT_EN
            pinc_d = (state_q == ST_IDLE) ? i_start_pinc : start_q;
`else
            pinc_d = i_start_pinc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            up_q        <= 1'b0;
            o_pinc      <= '0;
            o_poff      <= '0;
            o_cfg_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_pinc      <= pinc_d;
            o_cfg_valid <= timer_load;
            o_busy      <= (state_d == ST_LOAD) || (state_d == ST_DWELL) || (state_d == ST_STEP);
            o_done      <= (state_d == ST_FINISH);
            if (accept) begin
                stop_q  <= i_stop_pinc;
                step_q  <= i_step_pinc;
                dwell_q <= i_dwell;
                up_q    <= (i_start_pinc <= i_stop_pinc);
                o_poff  <= i_poff;
            end
        end
    end

`ifdef DDS_SWEEP_CONT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            cont_q  <= 1'b0;
        end else if (accept) begin
            start_q <= i_start_pinc;
            cont_q  <= i_cont;
        end
    end
`endif

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (i_abort),
        .i_load   (timer_load),
        .i_dwell  (timer_dwell),
        .o_expire (timer_expire)
    );

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Linear frequency-sweep sequencer for the DDS wrapper. On a start request it steps the DDS phase increment from a start value to a stop value in fixed increments. Each point is held for a programmable dwell time. Every new value is presented on the pinc/poff config bus with a one-cycle config-valid strobe, and the block ports connect directly to the wrapper's `i_pinc`/`i_poff`/`i_cfg_valid`.

## Interface
- `PINC_W`, 16: phase-increment/offset width; must match the DDS config field width.
- `DWELL_W`, 16: dwell counter width.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_start` in 1: sweep request; sampled only in IDLE.
- `i_abort` in 1: terminate the sweep; wins over all other events.
- `i_cont` in 1: continuous-repeat request; used only when the macro is defined.
- `i_start_pinc` in PINC_W: first increment.
- `i_stop_pinc` in PINC_W: last increment.
- `i_step_pinc` in PINC_W: unsigned step magnitude.
- `i_dwell` in DWELL_W: cycles per point; 0 is treated as 1.
- `i_poff` in PINC_W: phase offset, applied unchanged to every point.
- `o_pinc` out PINC_W: registered increment to DDS.
- `o_poff` out PINC_W: registered offset to DDS.
- `o_cfg_valid` out 1: one-cycle config strobe.
- `o_busy` out 1: high from the first strobe until the sweep ends.
- `o_done` out 1: one-cycle pulse on normal completion.

## Operation
- Configuration inputs are latched in the cycle `i_start` is accepted. Later input changes have no effect on the sweep in progress.
- Direction is up when start ≤ stop, otherwise down (unsigned compare).
- Next-value arithmetic is done in PINC_W+1 bits:
  - Up: next = cur + step; if next ≥ stop or it carries out, next = stop.
  - Down: if cur < step or cur − step ≤ stop, next = stop; otherwise next = cur − step.
- Point-count rules:
  - If step = 0 or start = stop, only one point (start) is emitted.
  - The stop value is always the last emitted point and is never overshot.
- FSM states: IDLE, LOAD, DWELL, STEP, FINISH.
  - IDLE → LOAD on `i_start`.
  - LOAD: drives start value with the strobe → DWELL.
  - DWELL: counts down the dwell. At expiry → STEP if cur ≠ stop, else FINISH.
  - STEP: drives next value with the strobe → DWELL.
  - FINISH: pulses `o_done` → IDLE.
- Abort: when `i_abort` is high in any non-IDLE state, the FSM goes to IDLE next cycle.
  - No further strobe and no `o_done`.
  - `o_pinc`/`o_poff` keep their last values, so the DDS keeps running at the last frequency.
- `i_start` and `i_abort` high together in IDLE: abort wins and the start is ignored.
- `i_start` outside IDLE is ignored.
- Reset (at any time, including mid-sweep): `o_pinc`=0, `o_poff`=0, `o_cfg_valid`=0, `o_busy`=0, `o_done`=0, FSM=IDLE, dwell counter=0.

## Timing
- All outputs are registered.
- `i_start` sampled high at edge T → `o_cfg_valid`=1 with `o_pinc`=start during cycle T+1. `o_busy` rises at T+1.
- Strobe spacing is exactly max(`i_dwell`,1) cycles, counted from strobe cycle to next strobe cycle. The STEP cycle is included in the dwell, not added to it.
- The last strobe is at cycle S. `o_done`=1 during S+D and `o_busy` falls in the same cycle. A new `i_start` is accepted at S+D+1 at the earliest.
- `o_cfg_valid` is never high in two consecutive cycles unless D=1.
- Each sweep produces exactly N strobes, where N = 1 + ceil(|stop−start|/step); N = 1 when step=0.

## Configuration
- Macro: `DDS_SWEEP_CONT_EN`.
- Defined: if `i_cont` was latched high at start, FINISH is replaced by reloading the start value. The next strobe carries start, D cycles after the stop strobe. The sweep repeats until `i_abort`, `o_done` never pulses, and `o_busy` stays high.
- Undefined: `i_cont` is ignored and the FSM is single-shot as above; no repeat logic is synthesized.

## Structure
- `dds_ctrl_pkg`:
  - FSM state enum type.
  - Default PINC_W/DWELL_W localparams.
  - A next-pinc function (saturating step toward stop, direction argument).
- Sub-module `dds_dwell_timer`: loadable down-counter with load value max(dwell,1), an expiry pulse, and clear on abort/reset.

## Test plan
- start=100, stop=140, step=10, dwell=4 → strobes with pinc 100,110,120,130,140, 4 cycles apart; first strobe at T+1; done at last strobe+4.
- start=140, stop=100, step=15, dwell=3 → pinc 140,125,110,100 (clamped); done once.
- step=0 or start=stop=500, dwell=0 → single strobe with pinc 500; done 1 cycle later.
- start=0xFFF0, stop=0xFFFF, step=0x20, dwell=2 → strobes 0xFFF0 then 0xFFFF; no wrap to low values.
- Abort asserted at the third dwell cycle of the 2nd point, and also `rst_n` low mid-sweep → no further strobe, no done. After abort `o_pinc` holds 110; after reset all outputs are 0 and busy is low.
- With `DDS_SWEEP_CONT_EN` defined and `i_cont`=1 on the first sweep → strobe sequence 100…140,100,110… with no done until abort.
